// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ops until both operands are known, selects the
// lowest-index ready entry each cycle, executes it and broadcasts (rob_id, value) on the RS bus.
module alu_reservation_station #(
  parameter int RS_SIZE      = 8,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_op,
  input  logic [ROB_ID_WIDTH-1:0] issue_rob_id,
  input  logic [31:0]             issue_vj,
  input  logic [31:0]             issue_vk,
  input  logic [ROB_ID_WIDTH-1:0] issue_qj,
  input  logic [ROB_ID_WIDTH-1:0] issue_qk,
  input  logic                    issue_j_rdy,
  input  logic                    issue_k_rdy,
  input  logic                    lsb_ready,
  input  logic [ROB_ID_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]             lsb_value,
  output logic                    rs_full,
  output logic                    rs_ready,
  output logic [ROB_ID_WIDTH-1:0] rs_rob_id,
  output logic [31:0]             rs_value
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]      busy_q, jr_q, kr_q;
  logic [3:0]              op_q  [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] rob_q [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qj_q  [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qk_q  [RS_SIZE];
  logic [31:0]             vj_q  [RS_SIZE];
  logic [31:0]             vk_q  [RS_SIZE];

  logic                    rs_ready_q;
  logic [ROB_ID_WIDTH-1:0] rs_rob_id_q;
  logic [31:0]             rs_value_q;

  logic             free_found, sel_found, ins_en;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic [RS_SIZE-1:0] j_hit, k_hit;
  logic [31:0]      j_wv [RS_SIZE];
  logic [31:0]      k_wv [RS_SIZE];
  logic             ins_jr_d, ins_kr_d;
  logic [31:0]      ins_vj_d, ins_vk_d, alu_res_d;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a & b;
      4'd3:    alu = a | b;
      4'd4:    alu = a ^ b;
      4'd5:    alu = a << b[4:0];
      4'd6:    alu = a >> b[4:0];
      4'd7:    alu = sa >>> b[4:0];
      4'd8:    alu = {31'd0, sa < sb};
      4'd9:    alu = {31'd0, a < b};
      4'd10:   alu = {31'd0, a == b};
      4'd11:   alu = {31'd0, a != b};
      4'd12:   alu = {31'd0, sa < sb};
      4'd13:   alu = {31'd0, sa >= sb};
      4'd14:   alu = {31'd0, a < b};
      default: alu = {31'd0, a >= b};
    endcase
  endfunction

  // Free-slot search, ready-entry select and bus snooping (wakeup + insert forwarding)
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy_q[i] && jr_q[i] && kr_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      j_hit[i] = 1'b0;
      k_hit[i] = 1'b0;
      j_wv[i]  = lsb_value;
      k_wv[i]  = lsb_value;
      if (rs_ready_q && rs_rob_id_q == qj_q[i]) begin
        j_hit[i] = busy_q[i] && !jr_q[i];
        j_wv[i]  = rs_value_q;
      end else if (lsb_ready && lsb_rob_id == qj_q[i]) begin
        j_hit[i] = busy_q[i] && !jr_q[i];
      end
      if (rs_ready_q && rs_rob_id_q == qk_q[i]) begin
        k_hit[i] = busy_q[i] && !kr_q[i];
        k_wv[i]  = rs_value_q;
      end else if (lsb_ready && lsb_rob_id == qk_q[i]) begin
        k_hit[i] = busy_q[i] && !kr_q[i];
      end
    end
    ins_jr_d = 1'b1;
    ins_vj_d = issue_vj;
    if (!issue_j_rdy) begin
      if (rs_ready_q && rs_rob_id_q == issue_qj)   ins_vj_d = rs_value_q;
      else if (lsb_ready && lsb_rob_id == issue_qj) ins_vj_d = lsb_value;
      else                                          ins_jr_d = 1'b0;
    end
    ins_kr_d = 1'b1;
    ins_vk_d = issue_vk;
    if (!issue_k_rdy) begin
      if (rs_ready_q && rs_rob_id_q == issue_qk)   ins_vk_d = rs_value_q;
      else if (lsb_ready && lsb_rob_id == issue_qk) ins_vk_d = lsb_value;
      else                                          ins_kr_d = 1'b0;
    end
    ins_en    = issue_valid && free_found;
    alu_res_d = alu(op_q[sel_idx], vj_q[sel_idx], vk_q[sel_idx]);
  end

  assign rs_full   = ~free_found;
  assign rs_ready  = rs_ready_q;
  assign rs_rob_id = rs_rob_id_q;
  assign rs_value  = rs_value_q;

  // Control state: occupancy, operand-ready flags and the result bus
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      jr_q        <= '0;
      kr_q        <= '0;
      rs_ready_q  <= 1'b0;
      rs_rob_id_q <= '0;
      rs_value_q  <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy_q      <= '0;
        rs_ready_q  <= 1'b0;
        rs_rob_id_q <= '0;
        rs_value_q  <= '0;
      end else begin
        jr_q <= jr_q | j_hit;
        kr_q <= kr_q | k_hit;
        if (sel_found) begin
          busy_q[sel_idx] <= 1'b0;
          rs_ready_q      <= 1'b1;
          rs_rob_id_q     <= rob_q[sel_idx];
          rs_value_q      <= alu_res_d;
        end else begin
          rs_ready_q <= 1'b0;
        end
        if (ins_en) begin
          busy_q[free_idx] <= 1'b1;
          jr_q[free_idx]   <= ins_jr_d;
          kr_q[free_idx]   <= ins_kr_d;
        end
      end
    end
  end

  // Entry payload; only meaningful while the matching busy bit is set
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (j_hit[i]) vj_q[i] <= j_wv[i];
        if (k_hit[i]) vk_q[i] <= k_wv[i];
      end
      if (ins_en) begin
        op_q[free_idx]  <= issue_op;
        rob_q[free_idx] <= issue_rob_id;
        qj_q[free_idx]  <= issue_qj;
        qk_q[free_idx]  <= issue_qk;
        vj_q[free_idx]  <= ins_vj_d;
        vk_q[free_idx]  <= ins_vk_d;
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed sequences, an ALU vector table and a randomized
// run, all cross-checked every cycle against a slot-array reference model.
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, issue_valid, issue_j_rdy, issue_k_rdy, lsb_ready;
  logic [3:0]  issue_op, issue_rob_id, issue_qj, issue_qk, lsb_rob_id;
  logic [31:0] issue_vj, issue_vk, lsb_value;
  logic        rs_full, rs_ready;
  logic [3:0]  rs_rob_id;
  logic [31:0] rs_value;

  int n_total = 0;
  int n_pass  = 0;

  alu_reservation_station #(.RS_SIZE(8), .ROB_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_j_rdy(issue_j_rdy), .issue_k_rdy(issue_k_rdy),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .rs_full(rs_full), .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value)
  );

  always #5 clk = ~clk;

  // Reference model: eight slots plus the result bus
  typedef struct {
    logic        busy;
    logic [3:0]  op, rob, qj, qk;
    logic [31:0] vj, vk;
    logic        jr, kr;
  } ent_t;

  ent_t        m [8];
  logic        m_ready;
  logic [3:0]  m_id;
  logic [31:0] m_val;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return $unsigned($signed(a) >>> sh);
      8, 12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      13: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      9, 14: return (a < b) ? 32'd1 : 32'd0;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  function automatic void model_edge();
    ent_t nx [8];
    int sel, fr;
    if (rst || (rdy && clear)) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_ready = 1'b0; m_id = '0; m_val = '0;
      return;
    end
    if (!rdy) return;
    nx = m;
    sel = -1; fr = -1;
    foreach (m[i]) begin
      if (!m[i].busy && fr < 0) fr = i;
      if (m[i].busy && m[i].jr && m[i].kr && sel < 0) sel = i;
      if (m[i].busy && !m[i].jr) begin
        if (m_ready && m_id == m[i].qj) begin nx[i].vj = m_val; nx[i].jr = 1'b1; end
        else if (lsb_ready && lsb_rob_id == m[i].qj) begin nx[i].vj = lsb_value; nx[i].jr = 1'b1; end
      end
      if (m[i].busy && !m[i].kr) begin
        if (m_ready && m_id == m[i].qk) begin nx[i].vk = m_val; nx[i].kr = 1'b1; end
        else if (lsb_ready && lsb_rob_id == m[i].qk) begin nx[i].vk = lsb_value; nx[i].kr = 1'b1; end
      end
    end
    if (sel >= 0) nx[sel].busy = 1'b0;
    if (issue_valid && fr >= 0) begin
      nx[fr].busy = 1'b1; nx[fr].op = issue_op; nx[fr].rob = issue_rob_id;
      nx[fr].qj = issue_qj; nx[fr].qk = issue_qk;
      nx[fr].vj = issue_vj; nx[fr].jr = issue_j_rdy;
      nx[fr].vk = issue_vk; nx[fr].kr = issue_k_rdy;
      if (!issue_j_rdy) begin
        if (m_ready && m_id == issue_qj) begin nx[fr].vj = m_val; nx[fr].jr = 1'b1; end
        else if (lsb_ready && lsb_rob_id == issue_qj) begin nx[fr].vj = lsb_value; nx[fr].jr = 1'b1; end
      end
      if (!issue_k_rdy) begin
        if (m_ready && m_id == issue_qk) begin nx[fr].vk = m_val; nx[fr].kr = 1'b1; end
        else if (lsb_ready && lsb_rob_id == issue_qk) begin nx[fr].vk = lsb_value; nx[fr].kr = 1'b1; end
      end
    end
    if (sel >= 0) begin
      m_ready = 1'b1; m_id = m[sel].rob; m_val = ref_alu(m[sel].op, m[sel].vj, m[sel].vk);
    end else begin
      m_ready = 1'b0;
    end
    m = nx;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model.rs_ready", 32'(rs_ready), 32'(m_ready));
    check("model.rs_rob_id", 32'(rs_rob_id), 32'(m_id));
    check("model.rs_value", rs_value, m_val);
    check("model.rs_full", 32'(rs_full), 32'(m_full()));
  endtask

  task automatic idle();
    issue_valid = 1'b0; lsb_ready = 1'b0; clear = 1'b0; rst = 1'b0; rdy = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rob, input logic [31:0] vj,
                       input logic [31:0] vk, input logic jr, input logic kr,
                       input logic [3:0] qj, input logic [3:0] qk);
    issue_valid = 1'b1; issue_op = op; issue_rob_id = rob;
    issue_vj = vj; issue_vk = vk; issue_j_rdy = jr; issue_k_rdy = kr;
    issue_qj = qj; issue_qk = qk;
  endtask

  task automatic expect_out(input string name, input logic r, input logic [3:0] id, input logic [31:0] v);
    check({name, ".ready"}, 32'(rs_ready), 32'(r));
    if (r) begin
      check({name, ".rob_id"}, 32'(rs_rob_id), 32'(id));
      check({name, ".value"}, rs_value, v);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  initial begin
    vec_t tbl [16];
    tbl[0]  = '{4'd0,  32'd5,         32'd7,         32'd12};
    tbl[1]  = '{4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE};
    tbl[2]  = '{4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    tbl[3]  = '{4'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0};
    tbl[4]  = '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0};
    tbl[5]  = '{4'd5,  32'd1,         32'd35,        32'd8};
    tbl[6]  = '{4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000};
    tbl[7]  = '{4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000};
    tbl[8]  = '{4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[9]  = '{4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[10] = '{4'd10, 32'd5,         32'd5,         32'd1};
    tbl[11] = '{4'd11, 32'd5,         32'd5,         32'd0};
    tbl[12] = '{4'd12, 32'd1,         32'hFFFF_FFFF, 32'd0};
    tbl[13] = '{4'd13, 32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[14] = '{4'd14, 32'd1,         32'hFFFF_FFFF, 32'd1};
    tbl[15] = '{4'd15, 32'd7,         32'd7,         32'd1};

    issue_op = '0; issue_rob_id = '0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0; issue_j_rdy = 1'b1; issue_k_rdy = 1'b1;
    lsb_rob_id = '0; lsb_value = '0;
    idle();
    rst = 1'b1;
    step(); step();
    check("reset.rs_ready", 32'(rs_ready), 32'd0);
    check("reset.rs_rob_id", 32'(rs_rob_id), 32'd0);
    check("reset.rs_value", rs_value, 32'd0);
    check("reset.rs_full", 32'(rs_full), 32'd0);
    idle();

    // 1: ready ADD -> one-cycle pulse one edge after insert
    issue(4'd0, 4'd3, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0);
    step(); idle();
    check("t1.ready_at_insert", 32'(rs_ready), 32'd0);
    step(); expect_out("t1", 1'b1, 4'd3, 32'd12);
    step(); check("t1.pulse_end", 32'(rs_ready), 32'd0);

    // 2: SUB waiting on tag 6, woken by LSB
    issue(4'd1, 4'd2, 32'd0, 32'd1, 1'b0, 1'b1, 4'd6, 4'd0);
    step(); idle();
    lsb_ready = 1'b1; lsb_rob_id = 4'd6; lsb_value = 32'd10;
    step(); idle();
    check("t2.not_yet", 32'(rs_ready), 32'd0);
    step(); expect_out("t2", 1'b1, 4'd2, 32'd9);
    step();

    // 3: insert-time forwarding from the RS bus
    issue(4'd0, 4'd1, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    step(); idle();
    step(); expect_out("t3.a", 1'b1, 4'd1, 32'd2);
    issue(4'd5, 4'd4, 32'd0, 32'd3, 1'b0, 1'b1, 4'd1, 4'd0);
    step(); idle();
    step(); expect_out("t3.b", 1'b1, 4'd4, 32'd16);
    step();

    // 4: fill on tag 9, ignored extra issue, in-order drain
    for (int i = 0; i < 8; i++) begin
      issue(4'd0, 4'(i), 32'd0, 32'(i), 1'b0, 1'b1, 4'd9, 4'd0);
      step();
      check("t4.full_fill", 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
    end
    issue(4'd0, 4'd15, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    step(); idle();
    check("t4.still_full", 32'(rs_full), 32'd1);
    check("t4.no_output", 32'(rs_ready), 32'd0);
    lsb_ready = 1'b1; lsb_rob_id = 4'd9; lsb_value = 32'd100;
    step(); idle();
    for (int i = 0; i < 8; i++) begin
      step();
      expect_out("t4.drain", 1'b1, 4'(i), 32'd100 + 32'(i));
      check("t4.full_drain", 32'(rs_full), 32'd0);
    end
    step(); check("t4.drained", 32'(rs_ready), 32'd0);

    // 5: ALU vector table
    foreach (tbl[i]) begin
      issue(tbl[i].op, 4'(i), tbl[i].a, tbl[i].b, 1'b1, 1'b1, 4'd0, 4'd0);
      step(); idle();
      step(); expect_out("t5.alu", 1'b1, 4'(i), tbl[i].exp);
    end
    step();

    // 6a: clear with waiting entries and a pending result
    for (int i = 0; i < 3; i++) begin
      issue(4'd0, 4'(8 + i), 32'd0, 32'd1, 1'b0, 1'b1, 4'd12, 4'd0);
      step();
    end
    issue(4'd0, 4'd11, 32'd2, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0);
    step(); idle();
    clear = 1'b1;
    step(); idle();
    check("t6.clear_ready", 32'(rs_ready), 32'd0);
    check("t6.clear_full", 32'(rs_full), 32'd0);
    check("t6.clear_value", rs_value, 32'd0);
    lsb_ready = 1'b1; lsb_rob_id = 4'd12; lsb_value = 32'd55;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step(); check("t6.no_late_output", 32'(rs_ready), 32'd0);
    end

    // 6b: rdy low freezes a live result and the queued op
    issue(4'd0, 4'd5, 32'd3, 32'd4, 1'b1, 1'b1, 4'd0, 4'd0);
    step();
    issue(4'd1, 4'd6, 32'd10, 32'd3, 1'b1, 1'b1, 4'd0, 4'd0);
    step(); idle();
    expect_out("t6.before_freeze", 1'b1, 4'd5, 32'd7);
    rdy = 1'b0;
    lsb_ready = 1'b1; lsb_rob_id = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("t6.frozen", 1'b1, 4'd5, 32'd7);
    end
    idle();
    step(); expect_out("t6.resume", 1'b1, 4'd6, 32'd7);
    step(); check("t6.after_resume", 32'(rs_ready), 32'd0);

    // Randomized run against the model
    for (int c = 0; c < 2000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 149) == 0);
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_op     = 4'($urandom);
      issue_rob_id = 4'($urandom);
      issue_vj     = $urandom;
      issue_vk     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue_j_rdy  = $urandom_range(0, 2) != 0;
      issue_k_rdy  = $urandom_range(0, 2) != 0;
      issue_qj     = 4'($urandom);
      issue_qk     = 4'($urandom);
      lsb_ready    = $urandom_range(0, 2) == 0;
      lsb_rob_id   = 4'($urandom);
      lsb_value    = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
